// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD lap counter: FSM state encoding, the largest
// legal BCD digit value, and the legal range of the DIGITS parameter.
// No ports; imported by bcd_digit_cell and bcd_lap_counter.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic bit digits_ok(input int d);
    return (d >= DIGITS_MIN) && (d <= DIGITS_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the counter's step logic (purely combinational).
// Ports: digit (current value), inc/dec (direction), carry_in (this digit steps),
//        next_digit (value after the step), carry_out (digit rolled 9->0 or 0->9).
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  output logic [3:0] next_digit,
  output logic       carry_out
);

  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (carry_in && inc) begin
      // Anything at or above 9 rolls over, so an illegal code can never persist.
      if (digit >= BCD_MAX) begin
        next_digit = 4'd0;
        carry_out  = 1'b1;
      end else begin
        next_digit = digit + 4'd1;
      end
    end else if (carry_in && dec) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        carry_out  = 1'b1;
      end else if (digit > BCD_MAX) begin
        next_digit = BCD_MAX;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_lap_counter.sv
// Multi-digit BCD stopwatch counter with run/pause, lap capture and wrap/saturate.
// Ports: clk, reset (async active-low), tick (count strobe), start_stop, lap_split,
//        clear, down (direction); count, display, state, terminal (bound pulse).
module bcd_lap_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start_stop,
  input  logic                  lap_split,
  input  logic                  clear,
  input  logic                  down,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   display,
  output logic [1:0]            state,
  output logic                  terminal
);

  if (!digits_ok(DIGITS)) begin : g_digits_range
    $error("bcd_lap_counter: DIGITS must be in the range 1..8");
  end

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic [4*DIGITS-1:0] stepped;
  logic [DIGITS:0]     carry;
  logic                term_q, term_d;
  logic                step, at_bound, lap_load, zero_load;

  // Counting is decided by the state before any coincident transition.
  assign step     = tick && ((state_q == ST_RUN) || (state_q == ST_LAP));
  assign carry[0] = step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_digit (
      .digit      (count_q[4*i +: 4]),
      .inc        (~down),
      .dec        (down),
      .carry_in   (carry[i]),
      .next_digit (stepped[4*i +: 4]),
      .carry_out  (carry[i+1])
    );
  end

  // A carry out of the top digit means the step crossed all-9 / all-0.
  assign at_bound = carry[DIGITS];

  // start_stop wins over lap_split, so both qualify on ~start_stop.
  assign lap_load  = ((state_q == ST_RUN) || (state_q == ST_LAP)) && !start_stop && lap_split;
  assign zero_load = (state_q == ST_PAUSE) && !start_stop && lap_split;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start_stop) state_d = ST_RUN;
        ST_RUN:   if (start_stop) state_d = ST_PAUSE;
                  else if (lap_split) state_d = ST_LAP;
        ST_LAP:   if (start_stop) state_d = ST_PAUSE;
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
                  else if (lap_split) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    state   = state_q;
    display = (state_q == ST_LAP) ? lap_q : count_q;
  end

  assign count    = count_q;
  assign terminal = term_q;

  // Datapath next values
  always_comb begin
    count_d = count_q;
    // In saturate mode a step at the bound leaves the count where it is.
    if (step && !(at_bound && (WRAP == 0))) begin
      count_d = stepped;
    end
    if (zero_load || clear) begin
      count_d = '0;
    end
  end

  // The lap register takes the post-edge count so a coincident tick is included.
  always_comb begin
    lap_d = lap_q;
    if (clear) begin
      lap_d = '0;
    end else if (lap_load) begin
      lap_d = count_d;
    end
  end

  assign term_d = !clear && at_bound;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      lap_q   <= '0;
      term_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      lap_q   <= lap_d;
      term_q  <= term_d;
    end
  end

endmodule

// File: doc/bcd_lap_counter.md
BCD_LAP_COUNTER -- requirements
Module: bcd_lap_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 5, giving the number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter WRAP, default 1: 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  as the reset: asynchronous, active-low.
REQ-005 SHALL have port tick  input  1  as a count-strobe qualifier; one count step per clk with tick=1.
REQ-006 SHALL have port start_stop  input  1  as a one-cycle command pulse that toggles run/pause.
REQ-007 SHALL have port lap_split  input  1  as a one-cycle command pulse: lap capture when counting, zeroing when paused.
REQ-008 SHALL have port clear  input  1  as a synchronous clear-to-idle command.
REQ-009 SHALL have port down  input  1  as count direction: 0 = up, 1 = down.
REQ-010 SHALL have port count  output  4*DIGITS  as the live BCD count, digit 0 in bits [3:0].
REQ-011 SHALL have port display  output  4*DIGITS  as the shown value: the lap register in LAP, otherwise count.
REQ-012 SHALL have port state  output  2  as the FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3.
REQ-013 SHALL have port terminal  output  1  as a one-cycle pulse on each wrap or saturation event.

Function
REQ-014 SHALL count only when the current state is RUN or LAP and tick=1; the new value appears on count the following cycle.
REQ-015 SHALL step up by incrementing digit 0 and carrying into digit k+1 only when digits 0..k are all 9, each carried digit going 9->0.
REQ-016 SHALL step down by decrementing digit 0 and borrowing into digit k+1 only when digits 0..k are all 0, each borrowed digit going 0->9.
REQ-017 SHALL never hold a digit value above 9.
REQ-018 SHALL, with WRAP=1, step up from all-9 to all-0, step down from all-0 to all-9, and pulse terminal for one cycle.
REQ-019 SHALL, with WRAP=0, hold count at all-9 (up) or all-0 (down) on a step attempted at that bound, pulsing terminal on every such attempted step.
REQ-020 SHALL implement these transitions: IDLE+start_stop->RUN; RUN+start_stop->PAUSE; RUN+lap_split->LAP.
REQ-021 SHALL implement these transitions: LAP+lap_split->LAP (re-capture); LAP+start_stop->PAUSE.
REQ-022 SHALL implement these transitions: PAUSE+start_stop->RUN; PAUSE+lap_split->IDLE with count zeroed.
REQ-023 SHALL hold the current state in every other state/input combination.
REQ-024 SHALL, on entry to or re-capture in LAP, load the lap register with the value count will hold after that same edge, so a coincident tick step is included.
REQ-025 SHALL let clear, from any state, force state to IDLE, count to 0, lap register to 0 and terminal to 0, overriding all other inputs that cycle.
REQ-026 SHALL give start_stop priority over lap_split when both are asserted in the same cycle.
REQ-027 SHALL decide counting from the state before a coincident transition: a tick in the IDLE->RUN cycle does not count; a tick in the RUN->PAUSE cycle does count.
REQ-028 SHALL ignore down changes except at the count step they qualify, with no re-synchronisation.
REQ-029 SHALL drive display combinationally from registers, adding no latency.

Reset
REQ-030 SHALL, on reset=0 and regardless of clk, force count=0, lap register=0, state=IDLE and terminal=0.
REQ-031 SHALL make display=0 during reset.
REQ-032 SHALL release reset with no spurious count or state change on the first clock after deassertion.

Structure
REQ-033 SHALL take the state encoding typedef, the BCD_MAX=9 constant and the DIGITS range check from shared package bcd_pkg.
REQ-034 SHALL build the count from one sub-module per digit, bcd_digit_cell, taking inc/dec/carry-in and producing next digit plus carry/borrow-out, chained DIGITS times.

Verification
REQ-035 SHALL be verified by: DIGITS=5, WRAP=1, up, count=99998, two ticks in RUN -> 99999, then 00000 with terminal high exactly one cycle.
REQ-036 SHALL be verified by: WRAP=0, down, count=00000, tick in RUN -> count stays 00000 and terminal pulses.
REQ-037 SHALL be verified by: RUN at count=00123, lap_split coincident with a tick -> state LAP, display frozen at 00124 while count keeps advancing.
REQ-038 SHALL be verified by: PAUSE at 00456, lap_split -> state IDLE, count 00000; start_stop plus tick in the same cycle -> RUN, count still 00000.
REQ-039 SHALL be verified by: start_stop and lap_split together in RUN -> PAUSE, no lap capture; clear with start_stop in PAUSE -> IDLE, count 0.
REQ-040 SHALL be verified by: reset asserted mid-count between clk edges -> all outputs 0 immediately, state IDLE.
